// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative encrypt/decrypt paths: round count,
// FSM states, S-box, rcon table and the byte-oriented round primitives.
package aes_pkg;

   localparam logic [3:0] NR = 4'd10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

   // Row-major S-box: entry b lives at bits [2047-8*b -: 8].
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[2047 - 8*int'(b) -: 8];
   endfunction

   // Round constants for rnd 1..10; other counter values never reach the datapath.
   function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return r;
   endfunction

   // Byte 4*c+r sits at row r, column c; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
      return r;
   endfunction

   // One step of the AES-128 key schedule: previous round key in, next round key out.
   function automatic logic [127:0] key_step(input logic [127:0] key, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = key;
      w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; the final round bypasses MixColumns.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output logic [127:0] next_state
);

   logic [127:0] shifted;
   logic [127:0] mixed;

   assign shifted    = shift_rows(sub_bytes(state));
   assign mixed      = last_round ? shifted : mix_columns(shifted);
   assign next_state = mixed ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock, key schedule expanded on the fly,
// ciphertext presented with a one-cycle valid pulse 10 clocks after the accept edge.
module aes_encrypt_iter
   import aes_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [127:0] in,
   input  logic [127:0] i_key,
   output logic [127:0] out,
   output logic         o_valid,
   output logic         o_busy
);

   aes_state_e   state;
   logic [127:0] state_reg;
   logic [127:0] key_reg;
   logic [127:0] next_key;
   logic [127:0] round_out;
   logic [3:0]   rnd;

   // The round key for round rnd is derived from the previous one in the same cycle it is used.
   assign next_key = key_step(key_reg, rcon_of(rnd));

   aes_enc_round u_round (
      .state      (state_reg),
      .round_key  (next_key),
      .last_round (rnd == NR),
      .next_state (round_out)
   );

   assign o_busy = (state == RUN);

   // NOTE: every register here is assigned with <= so all updates see pre-edge values,
   // letting state_reg, key_reg and rnd advance together without ordering hazards.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         rnd       <= '0;
         out       <= '0;
         o_valid   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state_reg <= in ^ i_key;
                  key_reg   <= i_key;
                  rnd       <= 4'd1;
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               state_reg <= round_out;
               key_reg   <= next_key;
               if (rnd == NR) begin
                  out     <= round_out;
                  o_valid <= 1'b1;
                  rnd     <= '0;
                  state   <= DONE;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known-answer and random vectors against a
// field-arithmetic AES model, plus back-to-back, ignored-start and mid-run reset sequences.
module tb_aes_encrypt_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_start;
   logic [127:0] pt;
   logic [127:0] key;
   logic [127:0] ct;
   logic         o_valid;
   logic         o_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] sbox_m [256];
   vec_t       vecs [9];

   aes_encrypt_iter dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .in      (pt),
      .i_key   (key),
      .out     (ct),
      .o_valid (o_valid),
      .o_busy  (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- reference model: GF(2^8) arithmetic from first principles
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                     ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                  ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               s[4*c+rr] = t[4*((c+rr)%4)+rr];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
               s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
         end
         for (int c = 0; c < 4; c++) begin
            tmp = w[4*r+c];
            for (int rr = 0; rr < 4; rr++) s[4*c+rr] = s[4*c+rr] ^ tmp[31-8*rr -: 8];
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Start one block from an idle DUT and verify latency, result, single pulse and hold.
   task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                            input logic [127:0] e, input string tag);
      int cycles;
      @(negedge i_clk);
      i_start = 1'b1; key = k; pt = p;
      @(negedge i_clk);
      i_start = 1'b0;
      key = rand128(); pt = rand128();
      check({tag, "_busy"}, o_busy, 1'b1);
      cycles = 0;
      while (!o_valid && cycles < 20) begin
         @(negedge i_clk);
         cycles++;
      end
      check({tag, "_latency"}, cycles, 10);
      check({tag, "_out"}, ct, e);
      @(negedge i_clk);
      check({tag, "_pulse_end"}, o_valid, 1'b0);
      check({tag, "_idle_busy"}, o_busy, 1'b0);
      repeat (3) @(negedge i_clk);
      check({tag, "_hold"}, ct, e);
   endtask

   initial begin
      int first, second, nvalid, busy_bad, vcyc;
      logic [127:0] out1, out2;

      build_sbox();
      i_rst = 1'b1; i_start = 1'b0; pt = '0; key = '0;
      repeat (2) @(negedge i_clk);
      i_start = 1'b1; pt = C1_PT; key = C1_KEY;
      @(negedge i_clk);
      check("rst_out", ct, 128'h0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      i_rst = 1'b0; i_start = 1'b0;
      @(negedge i_clk);
      check("post_rst_busy", o_busy, 1'b0);

      vecs[0] = '{C1_KEY, C1_PT, C1_CT};
      vecs[1] = '{B_KEY, B_PT, B_CT};
      vecs[2] = '{128'h0, 128'h0, Z_CT};
      for (int i = 3; i < 9; i++) begin
         vecs[i].key = rand128();
         vecs[i].pt  = rand128();
         vecs[i].ct  = model_encrypt(vecs[i].key, vecs[i].pt);
      end
      for (int i = 0; i < 9; i++)
         run_block(vecs[i].key, vecs[i].pt, vecs[i].ct, $sformatf("vec%0d", i));

      // Back-to-back with i_start held: C.1 then App. B.
      @(negedge i_clk);
      i_start = 1'b1; key = C1_KEY; pt = C1_PT;
      @(negedge i_clk);
      key = B_KEY; pt = B_PT;
      first = -1; second = -1; nvalid = 0; busy_bad = 0; out1 = '0; out2 = '0;
      for (int i = 0; i <= 21; i++) begin
         if (o_valid) begin
            nvalid++;
            if (first < 0) begin first = i; out1 = ct; end
            else begin second = i; out2 = ct; end
         end
         if (o_busy == o_valid) busy_bad++;
         if (i == 21) i_start = 1'b0;
         @(negedge i_clk);
      end
      check("b2b_first_cycle", first, 10);
      check("b2b_second_cycle", second, 21);
      check("b2b_out1", out1, C1_CT);
      check("b2b_out2", out2, B_CT);
      check("b2b_npulses", nvalid, 2);
      check("b2b_busy_pattern", busy_bad, 0);
      check("b2b_idle_after", o_busy, 1'b0);

      // A start pulse in mid-run must be ignored.
      @(negedge i_clk);
      i_start = 1'b1; key = C1_KEY; pt = C1_PT;
      @(negedge i_clk);
      i_start = 1'b0;
      nvalid = 0; vcyc = -1; out1 = '0;
      for (int i = 0; i < 15; i++) begin
         if (o_valid) begin nvalid++; vcyc = i; out1 = ct; end
         if (i == 5) begin i_start = 1'b1; key = rand128(); pt = rand128(); end
         if (i == 6) i_start = 1'b0;
         @(negedge i_clk);
      end
      check("ign_npulses", nvalid, 1);
      check("ign_cycle", vcyc, 10);
      check("ign_out", out1, C1_CT);
      check("ign_idle", o_busy, 1'b0);

      // Reset in the middle of a block.
      @(negedge i_clk);
      i_start = 1'b1; key = B_KEY; pt = B_PT;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (6) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      check("mrst_out", ct, 128'h0);
      check("mrst_valid", o_valid, 1'b0);
      check("mrst_busy", o_busy, 1'b0);
      i_rst = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge i_clk);
         if (o_valid || o_busy) nvalid++;
      end
      check("mrst_no_late_activity", nvalid, 0);
      run_block(C1_KEY, C1_PT, C1_CT, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
